// File: rtl/board.sv
// 2-D cell memory: combinational random read, synchronous single-cell write,
// and a saturating "increment the 8 neighbours" update for building adjacency counts.

module board_cell #(
  parameter int busWidth = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic                inc,
  input  logic [busWidth-1:0] wval,
  output logic [busWidth-1:0] q
);

  // wr and inc are never both set for the same cell, so their order is irrelevant.
  always_ff @(posedge clk) begin
    if (!reset)              q <= '0;
    else if (wr)             q <= wval;
    else if (inc && !(&q))   q <= q + 1'b1;
  end

endmodule

module board #(
  parameter int width    = 8,
  parameter int height   = 8,
  parameter int busWidth = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(width)-1:0]  readX,
  input  logic [$clog2(height)-1:0] readY,
  output logic [busWidth-1:0]       readValue,
  input  logic                      writeEn,
  input  logic [$clog2(width)-1:0]  writeX,
  input  logic [$clog2(height)-1:0] writeY,
  input  logic [busWidth-1:0]       writeValue,
  input  logic                      incAdjacent
);

  localparam int XW = $clog2(width);
  localparam int YW = $clog2(height);

  logic [height-1:0][width-1:0][busWidth-1:0] cells;

  // One extra bit so that +1 on the largest coordinate cannot wrap to 0.
  logic [XW:0] wx, rx;
  logic [YW:0] wy, ry;
  logic        centre_ok;

  assign wx        = {1'b0, writeX};
  assign wy        = {1'b0, writeY};
  assign rx        = {1'b0, readX};
  assign ry        = {1'b0, readY};
  assign centre_ok = (wx < (XW+1)'(width)) && (wy < (YW+1)'(height));

  for (genvar y = 0; y < height; y++) begin : g_row
    for (genvar x = 0; x < width; x++) begin : g_col
      localparam logic [XW:0] CX = (XW+1)'(x);
      localparam logic [YW:0] CY = (YW+1)'(y);

      logic near_x, near_y, centre, wr, inc;

      assign near_x = (wx + 1'b1 >= CX) && (wx <= CX + 1'b1);
      assign near_y = (wy + 1'b1 >= CY) && (wy <= CY + 1'b1);
      assign centre = (wx == CX) && (wy == CY);
      assign wr     = writeEn && centre;
      assign inc    = incAdjacent && centre_ok && near_x && near_y && !centre;

      board_cell #(.busWidth(busWidth)) u_cell (
        .clk  (clk),
        .reset(reset),
        .wr   (wr),
        .inc  (inc),
        .wval (writeValue),
        .q    (cells[y][x])
      );
    end
  end

  // Guard keeps non-power-of-2 boards from indexing past the last row/column.
  assign readValue = (rx < (XW+1)'(width) && ry < (YW+1)'(height)) ? cells[readY][readX] : '0;

endmodule

// File: tb/tb_board.sv
// Self-checking bench: an 8x8x4 count map and a 6x3x1 mine map checked against
// a coordinate-loop reference model, with directed steps followed by random traffic.

module tb_board;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, weA, incA;
  logic [2:0] rxA, ryA, wxA, wyA;
  logic [3:0] wvA, rvA;

  logic       rstB, weB, incB, wvB, rvB;
  logic [2:0] rxB, wxB;
  logic [1:0] ryB, wyB;

  board #(.width(8), .height(8), .busWidth(4)) dut_a (
    .clk(clk), .reset(rstA), .readX(rxA), .readY(ryA), .readValue(rvA),
    .writeEn(weA), .writeX(wxA), .writeY(wyA), .writeValue(wvA), .incAdjacent(incA)
  );

  board #(.width(6), .height(3), .busWidth(1)) dut_b (
    .clk(clk), .reset(rstB), .readX(rxB), .readY(ryB), .readValue(rvB),
    .writeEn(weB), .writeX(wxB), .writeY(wyB), .writeValue(wvB), .incAdjacent(incB)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: m[k][y][x], k=0 -> board A, k=1 -> board B.
  int m [2][8][8];
  int bw [2] = '{8, 6};
  int bh [2] = '{8, 3};
  int mx [2] = '{15, 1};

  function automatic int mread(int k, int x, int y);
    if (x < bw[k] && y < bh[k]) return m[k][y][x];
    return 0;
  endfunction

  task automatic mupdate(int k, int we, int x, int y, int v, int inc);
    if (x < bw[k] && y < bh[k]) begin
      if (inc != 0)
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = x + dx;
            ny = y + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && ny >= 0 && nx < bw[k] && ny < bh[k])
              m[k][ny][nx] = (m[k][ny][nx] + 1 > mx[k]) ? mx[k] : m[k][ny][nx] + 1;
          end
      if (we != 0) m[k][y][x] = v;
    end
  endtask

  task automatic chk(string tag, int x, int y, logic [31:0] obs, int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s (%0d,%0d) observed=%0d expected=%0d", tag, x, y, obs, exp);
    end
  endtask

  task automatic rdx(int k, int x, int y, int exp, string tag);
    if (k == 0) begin rxA = 3'(x); ryA = 3'(y); end
    else        begin rxB = 3'(x); ryB = 2'(y); end
    #1;
    chk(tag, x, y, (k == 0) ? {28'b0, rvA} : {31'b0, rvB}, exp);
  endtask

  task automatic rd(int k, int x, int y, string tag);
    rdx(k, x, y, mread(k, x, y), tag);
  endtask

  // Sweeps include the out-of-range coordinates of board B.
  task automatic sweep(int k, string tag);
    for (int y = 0; y < ((k == 0) ? 8 : 4); y++)
      for (int x = 0; x < 8; x++)
        rd(k, x, y, tag);
  endtask

  task automatic step(int k, int we, int x, int y, int v, int inc);
    @(negedge clk);
    if (k == 0) begin weA = 1'(we); wxA = 3'(x); wyA = 3'(y); wvA = 4'(v); incA = 1'(inc); end
    else        begin weB = 1'(we); wxB = 3'(x); wyB = 2'(y); wvB = 1'(v); incB = 1'(inc); end
    rd(k, x, y, "pre_edge_old");
    @(posedge clk);
    #1;
    weA = 1'b0; incA = 1'b0; weB = 1'b0; incB = 1'b0;
    mupdate(k, we, x, y, v, inc);
  endtask

  task automatic rst(int k, int n);
    @(negedge clk);
    if (k == 0) rstA = 1'b0; else rstB = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    if (k == 0) rstA = 1'b1; else rstB = 1'b1;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) m[k][y][x] = 0;
  endtask

  initial begin
    rstA = 1'b1; weA = 1'b0; incA = 1'b0; rxA = '0; ryA = '0; wxA = '0; wyA = '0; wvA = '0;
    rstB = 1'b1; weB = 1'b0; incB = 1'b0; rxB = '0; ryB = '0; wxB = '0; wyB = '0; wvB = '0;

    rst(0, 2);
    rst(1, 2);
    sweep(0, "reset_a");
    sweep(1, "reset_b");

    step(0, 0, 3, 3, 0, 1);
    sweep(0, "inc_interior");
    rdx(0, 3, 3, 0, "inc_centre");
    rdx(0, 2, 4, 1, "inc_nbr");
    rdx(0, 5, 3, 0, "inc_outside");

    rst(0, 1);
    step(0, 0, 0, 0, 0, 1);
    sweep(0, "inc_corner00");
    rdx(0, 1, 1, 1, "corner00_nbr");
    rdx(0, 7, 7, 0, "corner00_nowrap");

    rst(0, 1);
    step(0, 0, 7, 7, 0, 1);
    sweep(0, "inc_corner77");
    rdx(0, 6, 6, 1, "corner77_nbr");
    rdx(0, 0, 0, 0, "corner77_nowrap");

    rst(0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 2, 2, 0, 1);
    sweep(0, "saturate");
    rdx(0, 1, 1, 15, "sat_nbr");
    rdx(0, 2, 2, 0, "sat_centre");

    step(1, 1, 5, 1, 1, 0);
    sweep(1, "write_b");
    rdx(1, 5, 1, 1, "write_b_cell");
    step(1, 1, 6, 1, 1, 0);
    step(1, 0, 7, 2, 0, 1);
    step(1, 0, 2, 1, 0, 1);
    step(1, 0, 2, 1, 0, 1);
    sweep(1, "b_oor_and_sat");
    rst(1, 1);
    sweep(1, "reset_mid_b");

    rst(0, 1);
    step(0, 1, 4, 4, 9, 1);
    sweep(0, "write_and_inc");
    rdx(0, 4, 4, 9, "wi_centre");
    rdx(0, 3, 5, 1, "wi_nbr");

    for (int i = 0; i < 400; i++) begin
      int k;
      k = i % 2;
      step(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, (k == 0) ? 7 : 3)), int'($urandom_range(0, mx[k])),
           int'($urandom_range(0, 1)));
      rd(k, int'($urandom_range(0, 7)), int'($urandom_range(0, (k == 0) ? 7 : 3)), "rand_read");
      if (i % 100 == 99) begin
        sweep(0, "rand_sweep_a");
        sweep(1, "rand_sweep_b");
      end
      if (i == 250) rst(0, 1);
    end
    sweep(0, "final_a");
    sweep(1, "final_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
